mm_refill_arbiter: RTL and testbench

Sequencer and arbiter for main-memory access in the MIPS cache subsystem. It accepts line-refill requests from the instruction cache and the data cache and grants one requester at a time, round-robin. It then drives the main memory's access-enable/address pair for a configurable number of wait cycles followed by a burst of one full cache line. Each returned word is forwarded to the owning cache with a valid strobe and word index.

---
 rtl/mm_refill_arbiter_if.sv | 34 +++
 rtl/mm_refill_arbiter.sv | 90 +++++++++
 tb/tb_mm_refill_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mm_refill_arbiter_if.sv
// Refill bus between the I/D caches, main memory and the refill arbiter.
// The master side is the cache/memory side; the arbiter takes the slave modport.
interface mm_refill_arbiter_if #(
  parameter int unsigned WIDX = 2
);
  logic            I_REQ;
  logic [31:0]     I_ADDR;
  logic            D_REQ;
  logic [31:0]     D_ADDR;
  logic            I_GNT;
  logic            D_GNT;
  logic            I_VALID;
  logic            D_VALID;
  logic            I_DONE;
  logic            D_DONE;
  logic [31:0]     RDATA;
  logic [WIDX-1:0] RWORD;
  logic            MM_ACCESS;
  logic [31:0]     MM_ADDR;
  logic [31:0]     MM_DATA;
  logic            BUSY;

  modport master (
    output I_REQ, I_ADDR, D_REQ, D_ADDR, MM_DATA,
    input  I_GNT, D_GNT, I_VALID, D_VALID, I_DONE, D_DONE, RDATA, RWORD,
    input  MM_ACCESS, MM_ADDR, BUSY
  );

  modport slave (
    input  I_REQ, I_ADDR, D_REQ, D_ADDR, MM_DATA,
    output I_GNT, D_GNT, I_VALID, D_VALID, I_DONE, D_DONE, RDATA, RWORD,
    output MM_ACCESS, MM_ADDR, BUSY
  );
endinterface

// File: rtl/mm_refill_arbiter.sv
// Round-robin arbiter for I/D cache line refills: grant, wait LATENCY cycles,
// then burst one whole line out of main memory to the owning cache.
module mm_refill_arbiter #(
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned BLOCK_WORDS = 4,
  localparam int unsigned WIDX       = $clog2(BLOCK_WORDS)
) (
  input logic                CLK,
  input logic                RESET,
  mm_refill_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StWait, StBurst} state_e;

  localparam int unsigned     LowBits  = WIDX + 2;
  localparam logic [WIDX-1:0] LastIdx  = WIDX'(BLOCK_WORDS - 1);
  localparam logic [3:0]      WaitInit = 4'(LATENCY);

  state_e             state_q;
  logic               owner_q;  // 1: D-cache owns the current line
  logic               last_q;   // 1: D-cache was granted last
  logic [31:LowBits]  base_q;
  logic [WIDX-1:0]    idx_q;
  logic [3:0]         wcnt_q;

  logic        any_req;
  logic        pick_d;
  logic        grant;
  logic        in_burst;
  logic        last_word;
  logic [31:0] sel_addr;
  logic        unused_addr_bits;

  assign any_req   = bus.I_REQ | bus.D_REQ;
  // On a tie the requester that was not served last wins.
  assign pick_d    = bus.D_REQ & (~bus.I_REQ | ~last_q);
  assign grant     = RESET & (state_q == StIdle) & any_req;
  assign in_burst  = RESET & (state_q == StBurst);
  assign last_word = idx_q == LastIdx;
  assign sel_addr  = pick_d ? bus.D_ADDR : bus.I_ADDR;

  // Bursts always start at word 0, so the offset bits are dropped.
  assign unused_addr_bits = ^sel_addr[LowBits-1:0];

  assign bus.I_GNT     = grant & ~pick_d;
  assign bus.D_GNT     = grant & pick_d;
  assign bus.I_VALID   = in_burst & ~owner_q;
  assign bus.D_VALID   = in_burst & owner_q;
  assign bus.I_DONE    = in_burst & ~owner_q & last_word;
  assign bus.D_DONE    = in_burst & owner_q & last_word;
  assign bus.MM_ACCESS = in_burst;
  assign bus.MM_ADDR   = in_burst ? {base_q, idx_q, 2'b00} : '0;
  assign bus.RDATA     = in_burst ? bus.MM_DATA : '0;
  assign bus.RWORD     = in_burst ? idx_q : '0;
  assign bus.BUSY      = RESET & (state_q != StIdle);

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
      last_q  <= 1'b0;
      base_q  <= '0;
      idx_q   <= '0;
      wcnt_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (any_req) begin
            owner_q <= pick_d;
            last_q  <= pick_d;
            base_q  <= sel_addr[31:LowBits];
            idx_q   <= '0;
            wcnt_q  <= WaitInit;
            state_q <= (LATENCY == 0) ? StBurst : StWait;
          end
        end
        StWait: begin
          wcnt_q <= wcnt_q - 4'd1;
          if (wcnt_q == 4'd1) state_q <= StBurst;
        end
        StBurst: begin
          idx_q <= idx_q + WIDX'(1);
          if (last_word) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mm_refill_arbiter.sv
// Bench for mm_refill_arbiter: vector tables, directed corner sequences and a
// random run checked against a line-schedule model of the arbiter.
module tb_mm_refill_arbiter;

  localparam int unsigned Lat  = 2;
  localparam int unsigned Bw   = 4;
  localparam int unsigned Widx = 2;
  localparam logic [31:0] LineMask = 32'(Bw * 4 - 1);

  // fl = {I_GNT, D_GNT, I_VALID, D_VALID, I_DONE, D_DONE, MM_ACCESS, BUSY}
  typedef struct packed {
    logic [7:0]  fl;
    logic [31:0] maddr;
    logic [31:0] rdata;
    logic [1:0]  rword;
  } outs_t;

  typedef struct {
    bit          rst_n;
    bit          ireq;
    bit          dreq;
    logic [31:0] ia;
    logic [31:0] da;
    bit          z;
    outs_t       exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ireq;
  logic        dreq;
  logic [31:0] iaddr;
  logic [31:0] daddr;
  int          n_vec = 0;
  int          n_err = 0;
  vec_t        tbl[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  mm_refill_arbiter_if #(.WIDX(Widx)) bus ();
  mm_refill_arbiter_if #(.WIDX(Widx)) bus_z ();

  assign bus.I_REQ    = ireq;
  assign bus.D_REQ    = dreq;
  assign bus.I_ADDR   = iaddr;
  assign bus.D_ADDR   = daddr;
  assign bus.MM_DATA  = bus.MM_ACCESS ? memf(bus.MM_ADDR) : 32'hDEAD_BEEF;
  assign bus_z.I_REQ  = ireq;
  assign bus_z.D_REQ  = dreq;
  assign bus_z.I_ADDR = iaddr;
  assign bus_z.D_ADDR = daddr;
  assign bus_z.MM_DATA = bus_z.MM_ACCESS ? memf(bus_z.MM_ADDR) : 32'hDEAD_BEEF;

  mm_refill_arbiter #(.LATENCY(Lat), .BLOCK_WORDS(Bw)) dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus)
  );

  mm_refill_arbiter #(.LATENCY(0), .BLOCK_WORDS(Bw)) dut_z (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus_z)
  );

  function automatic outs_t sample(input bit z);
    outs_t o;
    if (z) begin
      o.fl    = {bus_z.I_GNT, bus_z.D_GNT, bus_z.I_VALID, bus_z.D_VALID,
                 bus_z.I_DONE, bus_z.D_DONE, bus_z.MM_ACCESS, bus_z.BUSY};
      o.maddr = bus_z.MM_ADDR;
      o.rdata = bus_z.RDATA;
      o.rword = bus_z.RWORD;
    end else begin
      o.fl    = {bus.I_GNT, bus.D_GNT, bus.I_VALID, bus.D_VALID,
                 bus.I_DONE, bus.D_DONE, bus.MM_ACCESS, bus.BUSY};
      o.maddr = bus.MM_ADDR;
      o.rdata = bus.RDATA;
      o.rword = bus.RWORD;
    end
    return o;
  endfunction

  task automatic chk_outs(input string nm, input outs_t act, input outs_t exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got fl=%b addr=%h data=%h word=%0d, want fl=%b addr=%h data=%h word=%0d",
               nm, $time, act.fl, act.maddr, act.rdata, act.rword,
               exp.fl, exp.maddr, exp.rdata, exp.rword);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d, want %0d", nm, $time, act, exp);
    end
  endtask

  function automatic void add(input bit r, input bit ir, input bit dr, input logic [31:0] ia,
                              input logic [31:0] da, input bit z, input logic [7:0] fl,
                              input logic [31:0] ma, input logic [1:0] rw);
    vec_t v;
    v.rst_n     = r;
    v.ireq      = ir;
    v.dreq      = dr;
    v.ia        = ia;
    v.da        = da;
    v.z         = z;
    v.exp.fl    = fl;
    v.exp.maddr = ma;
    v.exp.rword = rw;
    v.exp.rdata = (fl[5] | fl[4]) ? memf(ma) : 32'h0;
    tbl.push_back(v);
  endfunction

  // Reference: when idle, a grant schedules LATENCY wait cycles then one
  // beat per line word; a reset seen at an edge drops the whole schedule.
  outs_t       mq[$];
  bit          m_last = 1'b0;

  always begin
    outs_t       e;
    outs_t       w;
    bit          pd;
    bit          lw;
    logic [31:0] base;
    @(posedge clk);
    if (!rst_n) begin
      mq.delete();
      m_last = 1'b0;
    end
    @(negedge clk);
    e = '0;
    if (rst_n) begin
      if (mq.size() != 0) begin
        e = mq.pop_front();
      end else if (ireq || dreq) begin
        pd     = dreq && (!ireq || !m_last);
        m_last = pd;
        base   = (pd ? daddr : iaddr) & ~LineMask;
        e.fl   = pd ? 8'h40 : 8'h80;
        for (int k = 0; k < int'(Lat); k++) begin
          w    = '0;
          w.fl = 8'h01;
          mq.push_back(w);
        end
        for (int k = 0; k < int'(Bw); k++) begin
          lw      = (k == int'(Bw) - 1);
          w.fl    = {2'b00, !pd, pd, lw && !pd, lw && pd, 2'b11};
          w.maddr = base + 32'(4 * k);
          w.rdata = memf(w.maddr);
          w.rword = 2'(k);
          mq.push_back(w);
        end
      end
    end
    chk_outs("model", sample(1'b0), e);
  end

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.BUSY && n < 50);
    chk_int("idle_timeout", int'(bus.BUSY), 0);
  endtask

  initial begin
    int gcnt;
    int gwho[3];
    int gcyc[3];
    int done_c;
    bit found;

    rst_n = 1'b0;
    ireq  = 1'b0;
    dreq  = 1'b0;
    iaddr = '0;
    daddr = '0;

    // Single I line at 0x14, then a D pulse during I's wait.
    add(0, 0, 0, 32'h0,   32'h0,   0, 8'h00, 32'h0,  2'd0);
    add(1, 0, 0, 32'h0,   32'h0,   0, 8'h00, 32'h0,  2'd0);
    add(1, 1, 0, 32'h14,  32'h0,   0, 8'h80, 32'h0,  2'd0);
    add(1, 0, 0, 32'h0,   32'h0,   0, 8'h01, 32'h0,  2'd0);
    add(1, 0, 0, 32'h0,   32'h0,   0, 8'h01, 32'h0,  2'd0);
    add(1, 0, 0, 32'h0,   32'h0,   0, 8'h23, 32'h10, 2'd0);
    add(1, 0, 0, 32'h0,   32'h0,   0, 8'h23, 32'h14, 2'd1);
    add(1, 0, 0, 32'h0,   32'h0,   0, 8'h23, 32'h18, 2'd2);
    add(1, 0, 0, 32'h0,   32'h0,   0, 8'h2B, 32'h1C, 2'd3);
    add(1, 0, 0, 32'h0,   32'h0,   0, 8'h00, 32'h0,  2'd0);
    add(1, 1, 0, 32'h104, 32'h0,   0, 8'h80, 32'h0,  2'd0);
    add(1, 0, 1, 32'h0,   32'h200, 0, 8'h01, 32'h0,  2'd0);
    add(1, 0, 0, 32'h0,   32'h0,   0, 8'h01, 32'h0,  2'd0);
    add(1, 0, 0, 32'h0,   32'h0,   0, 8'h23, 32'h100, 2'd0);
    add(1, 0, 0, 32'h0,   32'h0,   0, 8'h23, 32'h104, 2'd1);
    add(1, 0, 0, 32'h0,   32'h0,   0, 8'h23, 32'h108, 2'd2);
    add(1, 0, 0, 32'h0,   32'h0,   0, 8'h2B, 32'h10C, 2'd3);
    add(1, 0, 0, 32'h0,   32'h0,   0, 8'h00, 32'h0,  2'd0);
    // Zero-latency instance, D line at 0x7C.
    add(0, 0, 0, 32'h0,   32'h0,   1, 8'h00, 32'h0,  2'd0);
    add(1, 0, 0, 32'h0,   32'h0,   1, 8'h00, 32'h0,  2'd0);
    add(1, 0, 1, 32'h0,   32'h7C,  1, 8'h40, 32'h0,  2'd0);
    add(1, 0, 0, 32'h0,   32'h0,   1, 8'h13, 32'h70, 2'd0);
    add(1, 0, 0, 32'h0,   32'h0,   1, 8'h13, 32'h74, 2'd1);
    add(1, 0, 0, 32'h0,   32'h0,   1, 8'h13, 32'h78, 2'd2);
    add(1, 0, 0, 32'h0,   32'h0,   1, 8'h17, 32'h7C, 2'd3);
    add(1, 0, 0, 32'h0,   32'h0,   1, 8'h00, 32'h0,  2'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk);
      #1;
      rst_n = tbl[i].rst_n;
      ireq  = tbl[i].ireq;
      dreq  = tbl[i].dreq;
      iaddr = tbl[i].ia;
      daddr = tbl[i].da;
      @(negedge clk);
      chk_outs($sformatf("vec%0d", i), sample(tbl[i].z), tbl[i].exp);
    end

    // Both requesting after reset: grants D, I, D one line occupancy apart.
    @(posedge clk); #1 rst_n = 1'b0; ireq = 1'b0; dreq = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1; ireq = 1'b1; dreq = 1'b1; iaddr = 32'h80; daddr = 32'h40;
    gcnt = 0;
    for (int g = 0; g < 3; g++) begin
      gwho[g] = -1;
      gcyc[g] = -1;
    end
    for (int c = 0; c < 40 && gcnt < 3; c++) begin
      @(negedge clk);
      if (bus.I_GNT || bus.D_GNT) begin
        gwho[gcnt] = int'(bus.D_GNT);
        gcyc[gcnt] = c;
        gcnt++;
      end
    end
    chk_int("rr_grant_count", gcnt, 3);
    for (int g = 0; g < 3; g++) begin
      chk_int($sformatf("rr_who%0d", g), gwho[g], (g % 2 == 0) ? 1 : 0);
      chk_int($sformatf("rr_cycle%0d", g), gcyc[g], g * int'(Lat + Bw + 1));
    end
    @(posedge clk); #1 ireq = 1'b0; dreq = 1'b0;
    wait_idle();

    // Reset while the second word is on the bus.
    @(posedge clk); #1 ireq = 1'b1; iaddr = 32'h300;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (bus.I_VALID && bus.RWORD == 2'd1) found = 1'b1;
    end
    chk_int("rword1_seen", int'(found), 1);
    #1 rst_n = 1'b0; ireq = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk_outs("post_reset_quiet", sample(1'b0), '0);
    @(posedge clk); #1 ireq = 1'b1; dreq = 1'b1; iaddr = 32'h500; daddr = 32'h600;
    @(negedge clk);
    chk_int("post_reset_dgnt", int'(bus.D_GNT), 1);
    chk_int("post_reset_ignt", int'(bus.I_GNT), 0);
    @(posedge clk); #1 ireq = 1'b0; dreq = 1'b0;
    wait_idle();

    // I_REQ held through DONE: re-grant right on the next IDLE cycle.
    @(posedge clk); #1 ireq = 1'b1; iaddr = 32'h900;
    gcnt   = 0;
    done_c = -1;
    gcyc[0] = -1;
    gcyc[1] = -1;
    for (int c = 0; c < 30 && gcnt < 2; c++) begin
      @(negedge clk);
      if (bus.I_DONE && done_c < 0) done_c = c;
      if (bus.I_GNT) begin
        gcyc[gcnt] = c;
        gcnt++;
      end
    end
    chk_int("held_grants", gcnt, 2);
    chk_int("held_done_cycle", done_c, int'(Lat + Bw));
    chk_int("held_regrant_cycle", gcyc[1], int'(Lat + Bw + 1));
    @(posedge clk); #1 ireq = 1'b0;
    wait_idle();

    // Random traffic with occasional resets.
    for (int c = 0; c < 800; c++) begin
      @(posedge clk);
      #1;
      rst_n = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 3) == 0) ireq = ~ireq;
      if ($urandom_range(0, 3) == 0) dreq = ~dreq;
      iaddr = $urandom();
      daddr = $urandom();
    end
    @(posedge clk); #1 ireq = 1'b0; dreq = 1'b0; rst_n = 1'b1;
    wait_idle();
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
